// File: rtl/batch_issue_scheduler_pkg.sv
// Shared widths, depth and FSM state encoding for the batch issue scheduler.
package batch_issue_scheduler_pkg;

   localparam int REQUEST_ID_WIDTH = 4;
   localparam int BANK_GROUP_WIDTH = 2;
   localparam int BANK_WIDTH       = 2;
   localparam int ROW_WIDTH        = 16;
   localparam int COLUMN_WIDTH     = 10;
   localparam int HIT_TAG_WIDTH    = 8;
   localparam int MAX_REQUESTS     = 1 << REQUEST_ID_WIDTH;

   typedef logic [REQUEST_ID_WIDTH-1:0] req_id_t;
   // One extra bit so scan and batch_n never wrap at the buffer end.
   typedef logic [REQUEST_ID_WIDTH:0]   req_cnt_t;

   typedef enum logic [2:0] {
      SCHED_IDLE    = 3'd0,
      SCHED_HEAD_RD = 3'd1,
      SCHED_HEAD_WT = 3'd2,
      SCHED_ISSUE   = 3'd3,
      SCHED_SCAN_RD = 3'd4,
      SCHED_SCAN_WT = 3'd5,
      SCHED_CLEAR   = 3'd6
   } sched_state_t;

endpackage

// File: rtl/batch_issue_scheduler_prio_find.sv
// Finds the lowest unissued buffer index in [start, batch_n); shared by head and scan lookups.
module issue_prio_find
   import batch_issue_scheduler_pkg::*;
(
   input  logic [MAX_REQUESTS-1:0] issued,
   input  req_cnt_t                start,
   input  req_cnt_t                batch_n,
   output logic                    found,
   output req_id_t                 idx
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      found = 1'b0;
      idx   = '0;
      // Walk downwards so the last match written is the lowest index.
      for (int i = MAX_REQUESTS - 1; i >= 0; i--) begin
         if (!issued[i] && (req_cnt_t'(i) >= start) && (req_cnt_t'(i) < batch_n)) begin
            found = 1'b1;
            idx   = req_id_t'(i);
         end
      end
   end

endmodule

// File: rtl/batch_issue_scheduler.sv
// Issues one frozen batch of buffered requests in first-ready row-hit order.
// Optional BATCH_TIMEOUT_EN starts a partial batch after TIMEOUT_CYCLES idle cycles.
module batch_issue_scheduler
   import batch_issue_scheduler_pkg::*;
#(
   parameter int BATCH_THRESHOLD = 8
`ifdef BATCH_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [REQUEST_ID_WIDTH-1:0] num_requests,
   output logic                        batch_start,
   output logic                        batch_clear,
   output logic [REQUEST_ID_WIDTH-1:0] rd_addr,
   input  logic [BANK_GROUP_WIDTH-1:0] rd_bank_group,
   input  logic [BANK_WIDTH-1:0]       rd_bank,
   input  logic [ROW_WIDTH-1:0]        rd_row,
   input  logic [COLUMN_WIDTH-1:0]     rd_column,
   input  logic [HIT_TAG_WIDTH-1:0]    rd_hit_tag,
   output logic                        cmd_valid,
   input  logic                        cmd_ready,
   output logic [REQUEST_ID_WIDTH-1:0] cmd_id,
   output logic [BANK_GROUP_WIDTH-1:0] cmd_bank_group,
   output logic [BANK_WIDTH-1:0]       cmd_bank,
   output logic [ROW_WIDTH-1:0]        cmd_row,
   output logic [COLUMN_WIDTH-1:0]     cmd_column,
   output logic                        cmd_row_hit,
   output logic                        busy
);

   localparam req_cnt_t THRESHOLD = req_cnt_t'(BATCH_THRESHOLD);

   sched_state_t              state;
   req_cnt_t                  batch_n;
   req_cnt_t                  scan;
   logic [MAX_REQUESTS-1:0]   issued;
   logic [HIT_TAG_WIDTH-1:0]  cur_tag;
   logic                      last_tag_valid;
   logic                      from_head;

   logic     found;
   req_id_t  found_idx;
   req_cnt_t find_start;
   logic     row_hit;
   logic     take;
   logic     start_batch;
   req_cnt_t next_scan;

   assign find_start = (state == SCHED_HEAD_RD) ? '0 : scan;
   assign next_scan  = {1'b0, rd_addr} + req_cnt_t'(1);

   issue_prio_find u_find (
      .issued  (issued),
      .start   (find_start),
      .batch_n (batch_n),
      .found   (found),
      .idx     (found_idx)
   );

   // Read data for rd_addr arrives in ISSUE, so the scan compare happens there too:
   // a head is always taken, a scanned entry only on a tag match.
   assign row_hit = last_tag_valid && (rd_hit_tag == cur_tag);
   assign take    = from_head || row_hit;

   assign cmd_valid      = (state == SCHED_ISSUE) && take;
   assign cmd_id         = cmd_valid ? rd_addr       : '0;
   assign cmd_bank_group = cmd_valid ? rd_bank_group : '0;
   assign cmd_bank       = cmd_valid ? rd_bank       : '0;
   assign cmd_row        = cmd_valid ? rd_row        : '0;
   assign cmd_column     = cmd_valid ? rd_column     : '0;
   assign cmd_row_hit    = cmd_valid && row_hit;
   assign busy           = (state != SCHED_IDLE);

`ifdef BATCH_TIMEOUT_EN
   localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [IDLE_W-1:0] idle_cnt;
   logic              timeout_hit;

   assign timeout_hit = (num_requests != '0) && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
   assign start_batch = (state == SCHED_IDLE) && (({1'b0, num_requests} >= THRESHOLD) || timeout_hit);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if ((state != SCHED_IDLE) || (num_requests == '0) || start_batch) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end
`else
   assign start_batch = (state == SCHED_IDLE) && ({1'b0, num_requests} >= THRESHOLD);
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (!rst_n) begin
         state          <= SCHED_IDLE;
         batch_start    <= 1'b0;
         batch_clear    <= 1'b0;
         rd_addr        <= '0;
         batch_n        <= '0;
         scan           <= '0;
         issued         <= '0;
         cur_tag        <= '0;
         last_tag_valid <= 1'b0;
         from_head      <= 1'b0;
      end else begin
         case (state)
            SCHED_IDLE: begin
               if (start_batch) begin
                  state          <= SCHED_HEAD_RD;
                  batch_start    <= 1'b1;
                  batch_n        <= {1'b0, num_requests};
                  issued         <= '0;
                  last_tag_valid <= 1'b0;
                  rd_addr        <= '0;
               end
            end
            SCHED_HEAD_RD: begin
               if (found) begin
                  rd_addr <= found_idx;
                  state   <= SCHED_HEAD_WT;
               end else begin
                  batch_clear <= 1'b1;
                  state       <= SCHED_CLEAR;
               end
            end
            SCHED_HEAD_WT: begin
               from_head <= 1'b1;
               state     <= SCHED_ISSUE;
            end
            SCHED_ISSUE: begin
               if (!take) begin
                  scan  <= next_scan;
                  state <= SCHED_SCAN_RD;
               end else if (cmd_ready) begin
                  issued[rd_addr] <= 1'b1;
                  cur_tag         <= rd_hit_tag;
                  last_tag_valid  <= 1'b1;
                  scan            <= next_scan;
                  state           <= SCHED_SCAN_RD;
               end
            end
            SCHED_SCAN_RD: begin
               if (found) begin
                  rd_addr <= found_idx;
                  state   <= SCHED_SCAN_WT;
               end else begin
                  state <= SCHED_HEAD_RD;
               end
            end
            SCHED_SCAN_WT: begin
               from_head <= 1'b0;
               state     <= SCHED_ISSUE;
            end
            SCHED_CLEAR: begin
               batch_clear <= 1'b0;
               batch_start <= 1'b0;
               state       <= SCHED_IDLE;
            end
            default: state <= SCHED_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_batch_issue_scheduler.sv
// Directed bench for batch_issue_scheduler with an expected-command scoreboard.
module tb_batch_issue_scheduler;
   import batch_issue_scheduler_pkg::*;

   typedef struct {
      int id;
      bit hit;
   } exp_t;

   logic                        clk;
   logic                        rst_n;
   logic [REQUEST_ID_WIDTH-1:0] num_requests;
   logic                        batch_start;
   logic                        batch_clear;
   logic [REQUEST_ID_WIDTH-1:0] rd_addr;
   logic [BANK_GROUP_WIDTH-1:0] rd_bank_group;
   logic [BANK_WIDTH-1:0]       rd_bank;
   logic [ROW_WIDTH-1:0]        rd_row;
   logic [COLUMN_WIDTH-1:0]     rd_column;
   logic [HIT_TAG_WIDTH-1:0]    rd_hit_tag;
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [REQUEST_ID_WIDTH-1:0] cmd_id;
   logic [BANK_GROUP_WIDTH-1:0] cmd_bank_group;
   logic [BANK_WIDTH-1:0]       cmd_bank;
   logic [ROW_WIDTH-1:0]        cmd_row;
   logic [COLUMN_WIDTH-1:0]     cmd_column;
   logic                        cmd_row_hit;
   logic                        busy;

   logic [ROW_WIDTH-1:0] mem_row [MAX_REQUESTS];
   exp_t q[$];
   int   tests_run = 0;
   int   tests_failed = 0;
   int   accepted = 0;
   int   clears = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   bit   chk_spacing = 0;

   batch_issue_scheduler #(
      .BATCH_THRESHOLD (4)
`ifdef BATCH_TIMEOUT_EN
      , .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .num_requests   (num_requests),
      .batch_start    (batch_start),
      .batch_clear    (batch_clear),
      .rd_addr        (rd_addr),
      .rd_bank_group  (rd_bank_group),
      .rd_bank        (rd_bank),
      .rd_row         (rd_row),
      .rd_column      (rd_column),
      .rd_hit_tag     (rd_hit_tag),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_id         (cmd_id),
      .cmd_bank_group (cmd_bank_group),
      .cmd_bank       (cmd_bank),
      .cmd_row        (cmd_row),
      .cmd_column     (cmd_column),
      .cmd_row_hit    (cmd_row_hit),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Request buffer model: one-cycle registered read, all requests in BG0/BK0.
   always @(posedge clk) begin
      rd_bank_group <= '0;
      rd_bank       <= '0;
      rd_row        <= mem_row[rd_addr];
      rd_column     <= COLUMN_WIDTH'(rd_addr);
      rd_hit_tag    <= mem_row[rd_addr][HIT_TAG_WIDTH-1:0];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int id, input bit hit);
      exp_t e;
      e.id  = id;
      e.hit = hit;
      q.push_back(e);
   endtask

   task automatic load_rows(input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] r2, input logic [15:0] r3);
      mem_row[0] = r0;
      mem_row[1] = r1;
      mem_row[2] = r2;
      mem_row[3] = r3;
   endtask

   // Handshake monitor: sees the final cmd_ready for the coming edge.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rst_n && cmd_valid && cmd_ready) begin
         check("sb_nonempty", (q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("cmd_id", cmd_id, e.id);
            check("cmd_row_hit", cmd_row_hit, e.hit);
            check("cmd_row", cmd_row, mem_row[e.id]);
         end
         if (chk_spacing && accepted > 0) check("cmd_spacing_ge3", ((cyc - last_cyc) >= 3), 1);
         last_cyc = cyc;
         accepted++;
      end
      if (rst_n && batch_clear) clears++;
   end

   task automatic wait_batch(input int stall_at, input int rst_at, input bit chk_start);
      bit seen = 0;
      bit stalled = 0;
      bit did_rst = 0;
      int base;
      base = clears;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge clk);
         if (chk_start) check("batch_start_held", batch_start, 1);
         if (batch_clear) begin
            seen = 1;
            num_requests = '0;
         end else if (stall_at >= 0 && !stalled && cmd_valid && accepted == stall_at) begin
            cmd_ready = 1'b0;
            stalled = 1;
            repeat (5) begin
               @(negedge clk);
               check("stall_valid", cmd_valid, 1);
               check("stall_id", cmd_id, stall_at);
               check("stall_row", cmd_row, mem_row[stall_at]);
            end
            cmd_ready = 1'b1;
         end else if (rst_at >= 0 && !did_rst && accepted == rst_at) begin
            rst_n = 1'b0;
            did_rst = 1;
            @(negedge clk);
            rst_n = 1'b1;
            check("rst_busy", busy, 0);
            check("rst_start", batch_start, 0);
            check("rst_valid", cmd_valid, 0);
            check("rst_clear", batch_clear, 0);
            q.delete();
            accepted = 0;
            base = clears;
            push(0, 0); push(1, 1); push(2, 1); push(3, 1);
         end
      end
      check("clear_seen", seen, 1);
      @(negedge clk);
      check("clear_one_cycle", batch_clear, 0);
      check("start_dropped", batch_start, 0);
      check("idle_no_valid", cmd_valid, 0);
      check("clear_count", clears - base, 1);
      check("sb_drained", q.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < MAX_REQUESTS; i++) mem_row[i] = '0;
      rst_n = 1'b0;
      num_requests = '0;
      cmd_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_start", batch_start, 0);
      check("reset_clear", batch_clear, 0);
      check("reset_valid", cmd_valid, 0);
      check("reset_rd_addr", rd_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Rows A,B,A,B: head then its row hit, then the next head.
      load_rows(16'h0011, 16'h0022, 16'h0011, 16'h0022);
      accepted = 0;
      push(0, 0); push(2, 1); push(1, 0); push(3, 1);
      num_requests = 4'd4;
      wait_batch(-1, -1, 0);

      // All one row, with batch_start held for the whole batch.
      load_rows(16'h0033, 16'h0033, 16'h0033, 16'h0033);
      accepted = 0;
      push(0, 0); push(1, 1); push(2, 1); push(3, 1);
      num_requests = 4'd4;
      wait_batch(-1, -1, 1);

      // Back-pressure on the second command.
      accepted = 0;
      push(0, 0); push(1, 1); push(2, 1); push(3, 1);
      num_requests = 4'd4;
      wait_batch(1, -1, 0);

      // Reset after the second accepted command; batch restarts at id 0.
      accepted = 0;
      push(0, 0); push(1, 1); push(2, 1); push(3, 1);
      num_requests = 4'd4;
      wait_batch(-1, 2, 0);

      // Four distinct rows: strict index order, no hits.
      load_rows(16'h0101, 16'h0202, 16'h0303, 16'h0404);
      accepted = 0;
      chk_spacing = 1;
      push(0, 0); push(1, 0); push(2, 0); push(3, 0);
      num_requests = 4'd4;
      wait_batch(-1, -1, 0);
      chk_spacing = 0;

`ifdef BATCH_TIMEOUT_EN
      begin
         int n = 0;
         load_rows(16'h0505, 16'h0606, 16'h0000, 16'h0000);
         accepted = 0;
         push(0, 0); push(1, 0);
         num_requests = 4'd2;
         for (int c = 0; c < 40 && !batch_start; c++) begin
            @(negedge clk);
            n++;
         end
         check("timeout_latency", n, 16);
         wait_batch(-1, -1, 0);
      end
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
